// File: rtl/fpu_req_scheduler_if.sv
// Bundle of requester-side and FPU-side signals around fpu_req_scheduler.
// slave = the scheduler, master = the environment (requesters plus the FPU).
//
// Handshakes: req is a level held until the one-cycle gnt that accepts it.
// fpu_doorbell and fpu_done are one-cycle pulses. rsp_valid stays high and
// rsp_result/rsp_flags stay stable until the matching rsp_ack bit is seen.
interface fpu_req_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 4
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*OP_W-1:0] req_op;
  logic [NUM_REQ*32-1:0]   req_a;
  logic [NUM_REQ*32-1:0]   req_b;
  logic [NUM_REQ-1:0]      int_en;
  logic [NUM_REQ-1:0]      gnt;
  logic                    fpu_doorbell;
  logic [OP_W-1:0]         fpu_op;
  logic [31:0]             fpu_a;
  logic [31:0]             fpu_b;
  logic                    fpu_done;
  logic [31:0]             fpu_result;
  logic [3:0]              fpu_flags;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ-1:0]      rsp_ack;
  logic [31:0]             rsp_result;
  logic [3:0]              rsp_flags;
  logic [NUM_REQ-1:0]      irq;

  modport slave (
    input  req, req_op, req_a, req_b, int_en, fpu_done, fpu_result, fpu_flags, rsp_ack,
    output gnt, fpu_doorbell, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_result, rsp_flags, irq
  );

  modport master (
    output req, req_op, req_a, req_b, int_en, fpu_done, fpu_result, fpu_flags, rsp_ack,
    input  gnt, fpu_doorbell, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_result, rsp_flags, irq
  );
endinterface

// File: rtl/fpu_req_scheduler.sv
// Round-robin scheduler sharing one FPU among NUM_REQ requesters, one op at a time.
// Optional FPU_SCHED_TIMEOUT_EN: WAIT gives up after 1024 cycles with a qNaN/invalid result.
module fpu_req_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int OP_W     = 4,
  parameter int RR_PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  fpu_req_scheduler_if.slave    bus,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic [RR_PTR_W-1:0]  rr_ptr;
  logic [RR_PTR_W-1:0]  sel_q;
  logic [RR_PTR_W-1:0]  pick_idx;
  logic                 pick_valid;
  logic [NUM_REQ-1:0]   gnt_c;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic                 doorbell_c;
  logic                 timeout_hit;

  // Index base+off wrapped into 0..NUM_REQ-1, so non-power-of-two counts never alias.
  function automatic logic [RR_PTR_W-1:0] wrap_idx(input logic [RR_PTR_W-1:0] base,
                                                   input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return RR_PTR_W'(s);
  endfunction

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && bus.req[wrap_idx(rr_ptr, i)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(rr_ptr, i);
      end
    end
  end

  assign sel_onehot = NUM_REQ'(1) << sel_q;

`ifdef FPU_SCHED_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  assign timeout_hit = (state == WAIT) && !bus.fpu_done && (wait_cnt == 16'd1023);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    gnt_c      = '0;
    doorbell_c = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          gnt_c    = NUM_REQ'(1) << pick_idx;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        doorbell_c = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        if (bus.fpu_done || timeout_hit) state_nx = RESP;
      end
      RESP: begin
        if (bus.rsp_ack[sel_q]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // gnt is combinational from req in IDLE, so hold it low while reset is applied.
  assign bus.gnt          = reset ? '0 : gnt_c;
  assign bus.fpu_doorbell = reset ? 1'b0 : doorbell_c;
  assign busy             = (state != IDLE);
  assign state_dbg        = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      sel_q          <= '0;
      bus.fpu_op     <= '0;
      bus.fpu_a      <= '0;
      bus.fpu_b      <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.irq        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel_q      <= pick_idx;
            bus.fpu_op <= bus.req_op[pick_idx*OP_W +: OP_W];
            bus.fpu_a  <= bus.req_a[pick_idx*32 +: 32];
            bus.fpu_b  <= bus.req_b[pick_idx*32 +: 32];
          end
        end
        WAIT: begin
          if (bus.fpu_done) begin
            bus.rsp_result <= bus.fpu_result;
            bus.rsp_flags  <= bus.fpu_flags;
            bus.rsp_valid  <= sel_onehot;
            bus.irq        <= sel_onehot & bus.int_en;
          end else if (timeout_hit) begin
            bus.rsp_result <= 32'h7FC0_0000;
            bus.rsp_flags  <= 4'b1000;
            bus.rsp_valid  <= sel_onehot;
            bus.irq        <= sel_onehot & bus.int_en;
          end
        end
        RESP: begin
          if (bus.rsp_ack[sel_q]) begin
            bus.rsp_valid <= '0;
            bus.irq       <= '0;
            rr_ptr        <= (sel_q == RR_PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fpu_req_scheduler.md
Name: fpu_req_scheduler

Overview:
- Shares one FPU datapath and its output register stage among NUM_REQ requesters using round-robin arbitration.
- Per operation it grants one requester, issues the operands to the FPU, waits for completion, and captures result and flags.
- It then returns the result to the granted requester through a valid/ack handshake and raises an optional per-requester interrupt.
- It sits between the core-side requesters and the FPU result/ready register path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- OP_W, 4, opcode width.
- RR_PTR_W, 2, round-robin pointer width; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester operation request; level, held until gnt.
- req_op  in  NUM_REQ*OP_W  packed opcodes; slot i at [i*OP_W +: OP_W].
- req_a  in  NUM_REQ*32  packed operand A.
- req_b  in  NUM_REQ*32  packed operand B.
- int_en  in  NUM_REQ  per-requester interrupt enable.
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse accepting a request.
- fpu_doorbell  out  1  1-cycle start pulse to the FPU.
- fpu_op  out  OP_W  registered opcode to the FPU.
- fpu_a  out  32  registered operand A to the FPU.
- fpu_b  out  32  registered operand B to the FPU.
- fpu_done  in  1  1-cycle completion pulse from the FPU.
- fpu_result  in  32  FPU result, valid with fpu_done.
- fpu_flags  in  4  FPU flags, valid with fpu_done.
- rsp_valid  out  NUM_REQ  one-hot response valid; held until rsp_ack.
- rsp_ack  in  NUM_REQ  requester acknowledge.
- rsp_result  out  32  captured result.
- rsp_flags  out  4  captured flags.
- irq  out  NUM_REQ  per-requester interrupt level.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; state IDLE; rr_ptr = 0.
  - Reset mid-operation abandons the operation; any later fpu_done is ignored until the next issue.
- States IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr upward with wrap-around.
  - Same cycle: gnt[k]=1; latch req_op/req_a/req_b slot k into fpu_op/fpu_a/fpu_b; store k; go to ISSUE.
- ISSUE:
  - fpu_doorbell=1 for exactly one cycle; go to WAIT.
- WAIT:
  - On fpu_done: capture fpu_result into rsp_result and fpu_flags into rsp_flags; set rsp_valid[k]; set irq[k] if int_en[k]; go to RESP.
  - fpu_done in any state other than WAIT is ignored.
- RESP:
  - rsp_valid[k], rsp_result and rsp_flags are held stable.
  - On rsp_ack[k]: clear rsp_valid[k] and irq[k]; rr_ptr = (k+1) mod NUM_REQ; go to IDLE.
  - rsp_ack on any other bit is ignored.
- Latency:
  - gnt to fpu_doorbell: 1 cycle.
  - fpu_done to rsp_valid: 1 cycle (registered).
  - rsp_ack to next possible gnt: 1 cycle.
- Only one operation is outstanding at a time; no pipelining.
- Fairness: a requester that is continuously asserting is granted within NUM_REQ operations.
- A requester dropping req before gnt is legal; that request is lost and no gnt is given for it.
- Simultaneous events:
  - req of other requesters during RESP waits for IDLE.
  - rsp_ack and a new req from the same requester in the same cycle: ack is processed first; the new req is arbitrated in IDLE.
- rr_ptr wraps from NUM_REQ-1 to 0; for non-power-of-two NUM_REQ, pointer values >= NUM_REQ are never produced.

Optional Feature:
- Macro FPU_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT.
  - If fpu_done has not arrived after 1024 cycles: go to RESP with rsp_result=32'h7FC0_0000 (qNaN) and rsp_flags=4'b1000 (invalid); irq[k] per int_en[k].
  - Counter clears on entering WAIT.
- Undefined: WAIT has no limit; no counter logic is present.

Test Plan:
- Single requester: req[0], a=32'h3F80_0000, b=32'h4000_0000, FPU model returns 32'h4040_0000 and flags 4'b0000 after 5 cycles -> gnt[0] in cycle 1, doorbell in cycle 2, rsp_valid[0] with 32'h4040_0000 one cycle after fpu_done, cleared the cycle after rsp_ack[0].
- All four req held high, ack immediately -> gnt order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- int_en=4'b0100, op from requester 2 -> irq[2] rises with rsp_valid[2] and falls after rsp_ack[2]; irq[0] stays 0 for a requester-0 op.
- Spurious fpu_done in IDLE and RESP -> rsp_result unchanged, no state change.
- Reset asserted in WAIT, then a late fpu_done -> all outputs 0; rsp_valid stays 0; next req is granted normally from rr_ptr=0.
- FPU_SCHED_TIMEOUT_EN defined, FPU never returns fpu_done -> rsp_valid after 1024 WAIT cycles with 32'h7FC0_0000 and flags 4'b1000.
